// File: rtl/brdg_cmd_pkg.sv
// Shared types and constants for the AXI slave command queue and its 4KB splitter.
package brdg_cmd_pkg;

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        SECOND = 1'b1
    } split_state_e;

    localparam int unsigned PAGE_4K    = 4096;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    // Packed command layout: {id, addr, len, size, burst, user}
    function automatic int unsigned cmd_width(input int unsigned idw, input int unsigned ctxw);
        return idw + 64 + 8 + 3 + 2 + ctxw;
    endfunction

endpackage

// File: rtl/brdg_cmd_4k_splitter.sv
// Splits an INCR head command that crosses a 4KB page into two back-to-back commands.
module brdg_cmd_4k_splitter
    import brdg_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        head_valid,
    input  logic [63:0] head_addr,
    input  logic [7:0]  head_len,
    input  logic [2:0]  head_size,
    input  logic [1:0]  head_burst,
    input  logic        out_ready,
    output logic [63:0] out_addr,
    output logic [7:0]  out_len,
    output logic        out_split,
    output logic        pop
);

    split_state_e state, state_next;

    logic [15:0] span_bytes;
    logic [16:0] span_end;
    logic [12:0] page_room;
    logic [12:0] first_beats;
    logic [7:0]  len1;
    logic [7:0]  len2;
    logic [63:0] next_page;
    logic        crosses;

    // Page-boundary arithmetic on the current head
    always_comb begin
        span_bytes  = ({8'd0, head_len} + 16'd1) << head_size;
        span_end    = 17'(head_addr[11:0]) + 17'(span_bytes);
        crosses     = (head_burst == BURST_INCR) && (span_end > 17'(PAGE_4K));
        page_room   = 13'(PAGE_4K) - 13'(head_addr[11:0]);
        first_beats = page_room >> head_size;
        len1        = 8'(first_beats - 13'd1);
        len2        = head_len - len1 - 8'd1;
        next_page   = {head_addr[63:12] + 52'd1, 12'h000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PASS:    if (head_valid && crosses && out_ready) state_next = SECOND;
            SECOND:  if (head_valid && out_ready) state_next = PASS;
            default: state_next = PASS;
        endcase
    end

    // First half keeps the address; second half starts on the next page and pops
    always_comb begin
        out_addr  = head_addr;
        out_len   = head_len;
        out_split = 1'b0;
        pop       = 1'b0;
        case (state)
            PASS: begin
                if (crosses) begin
                    out_len   = len1;
                    out_split = head_valid;
                end else begin
                    pop = head_valid && out_ready;
                end
            end
            SECOND: begin
                out_addr = next_page;
                out_len  = len2;
                pop      = head_valid && out_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/brdg_axi_slave_cmd_queue.sv
// First-word-fall-through AXI AW/AR command queue with early (almost-full) backpressure.
// Optional 4KB burst splitting on the output is enabled by BRDG_CMD_4K_SPLIT_EN.
module brdg_axi_slave_cmd_queue
    import brdg_cmd_pkg::*;
#(
    parameter int unsigned IDW        = 5,
    parameter int unsigned CTXW       = 9,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IDW-1:0]        s_id,
    input  logic [63:0]           s_addr,
    input  logic [7:0]            s_len,
    input  logic [2:0]            s_size,
    input  logic [1:0]            s_burst,
    input  logic [CTXW-1:0]       s_user,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IDW-1:0]        m_id,
    output logic [63:0]           m_addr,
    output logic [7:0]            m_len,
    output logic [2:0]            m_size,
    output logic [1:0]            m_burst,
    output logic [CTXW-1:0]       m_user,
    output logic                  m_split,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned PW     = DEPTH_LOG2 + 1;
    localparam int unsigned CW     = cmd_width(IDW, CTXW);
    localparam int unsigned THRESH = DEPTH - AF_MARGIN;

    logic [CW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count_next;
    logic [CW-1:0]   head;
    logic            push;
    logic            pop;

    logic [IDW-1:0]  h_id;
    logic [63:0]     h_addr;
    logic [7:0]      h_len;
    logic [2:0]      h_size;
    logic [1:0]      h_burst;
    logic [CTXW-1:0] h_user;

    assign push = s_valid && s_ready;
    assign head = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign {h_id, h_addr, h_len, h_size, h_burst, h_user} = head;

    always_comb begin
        count_next = count + PW'(push) - PW'(pop);
    end

    // Pointers wrap naturally; the extra MSB separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count   <= count_next;
            s_ready <= (count_next < PW'(THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_id, s_addr, s_len, s_size, s_burst, s_user};
        end
    end

    assign m_valid = (count != '0);
    assign m_id    = h_id;
    assign m_size  = h_size;
    assign m_burst = h_burst;
    assign m_user  = h_user;

`ifdef BRDG_CMD_4K_SPLIT_EN
    brdg_cmd_4k_splitter u_splitter (
        .clk        (clk),
        .rst        (rst),
        .head_valid (m_valid),
        .head_addr  (h_addr),
        .head_len   (h_len),
        .head_size  (h_size),
        .head_burst (h_burst),
        .out_ready  (m_ready),
        .out_addr   (m_addr),
        .out_len    (m_len),
        .out_split  (m_split),
        .pop        (pop)
    );
`else
    assign m_addr  = h_addr;
    assign m_len   = h_len;
    assign m_split = 1'b0;
    assign pop     = m_valid && m_ready;
`endif

endmodule

// File: tb/tb_brdg_axi_slave_cmd_queue.sv
// Directed self-checking bench for brdg_axi_slave_cmd_queue (default parameters).
module tb_brdg_axi_slave_cmd_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_id = '0;
    logic [63:0] s_addr = '0;
    logic [7:0]  s_len = '0;
    logic [2:0]  s_size = '0;
    logic [1:0]  s_burst = '0;
    logic [8:0]  s_user = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [4:0]  m_id;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    logic [8:0]  m_user;
    logic        m_split;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    brdg_axi_slave_cmd_queue dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_id    (s_id),
        .s_addr  (s_addr),
        .s_len   (s_len),
        .s_size  (s_size),
        .s_burst (s_burst),
        .s_user  (s_user),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_id    (m_id),
        .m_addr  (m_addr),
        .m_len   (m_len),
        .m_size  (m_size),
        .m_burst (m_burst),
        .m_user  (m_user),
        .m_split (m_split),
        .count   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_addr(input int k);
        return 64'h0000_0002_0000_0000 + 64'(k) * 64'h100;
    endfunction

    function automatic logic [4:0] exp_id(input int k);
        return 5'(k);
    endfunction

    function automatic logic [7:0] exp_len(input int k);
        return 8'(k % 4);
    endfunction

    function automatic logic [8:0] exp_user(input int k);
        return 9'(k * 3);
    endfunction

    task automatic drive_cmd(input int k);
        s_id    = exp_id(k);
        s_addr  = exp_addr(k);
        s_len   = exp_len(k);
        s_size  = 3'd2;
        s_burst = 2'b01;
        s_user  = exp_user(k);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b expected 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (m_split !== 1'b0) begin errors++; $display("FAIL reset_m_split: got %0b expected 0", m_split); end
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_s_ready: got %0b expected 1", s_ready); end
    endtask

    task automatic test_single();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_pre_ready: got %0b expected 1", s_ready); end
        s_id = 5'd3; s_addr = 64'h1000; s_len = 8'd0; s_size = 3'd2; s_burst = 2'b01; s_user = 9'h155;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_m_valid: got %0b expected 1", m_valid); end
        checks++;
        if (m_id !== 5'd3 || m_addr !== 64'h1000 || m_len !== 8'd0 || m_size !== 3'd2 ||
            m_burst !== 2'b01 || m_user !== 9'h155 || m_split !== 1'b0) begin
            errors++;
            $display("FAIL single_fields: got id=%0h addr=%0h len=%0h size=%0h burst=%0h user=%0h split=%0b expected id=3 addr=1000 len=0 size=2 burst=1 user=155 split=0",
                     m_id, m_addr, m_len, m_size, m_burst, m_user, m_split);
        end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0: got %0d expected 0", count); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %0b expected 0", m_valid); end
    endtask

    task automatic test_fill();
        int k = 0;
        int rd = 0;
        int cyc = 0;
        logic acc_push;
        logic acc_pop;
        m_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (k < 16) begin drive_cmd(k); s_valid = 1'b1; end
            else s_valid = 1'b0;
            acc_push = s_valid && s_ready;
            tick();
            if (acc_push) k++;
        end
        checks++; if (k !== 14) begin errors++; $display("FAIL fill_accepts: got %0d expected 14", k); end
        checks++; if (count !== 5'd14) begin errors++; $display("FAIL fill_count: got %0d expected 14", count); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %0b expected 0", s_ready); end
        m_ready = 1'b1;
        while (rd < 16 && cyc < 200) begin
            if (k < 16) begin drive_cmd(k); s_valid = 1'b1; end
            else s_valid = 1'b0;
            acc_push = s_valid && s_ready;
            acc_pop  = m_valid && m_ready;
            if (m_valid) begin
                checks++;
                if (m_id !== exp_id(rd) || m_addr !== exp_addr(rd) || m_len !== exp_len(rd) || m_user !== exp_user(rd)) begin
                    errors++;
                    $display("FAIL fill_order[%0d]: got id=%0h addr=%0h expected id=%0h addr=%0h", rd, m_id, m_addr, exp_id(rd), exp_addr(rd));
                end
            end
            tick();
            if (acc_push) k++;
            if (acc_pop) rd++;
            cyc++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (rd !== 16) begin errors++; $display("FAIL fill_drain_timeout: got %0d delivered expected 16", rd); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_simul();
        int k = 0;
        int rd = 0;
        int cyc = 0;
        logic acc_push;
        logic acc_pop;
        m_ready = 1'b0;
        while (k < 5 && cyc < 20) begin
            drive_cmd(100 + k); s_valid = 1'b1;
            acc_push = s_ready;
            tick();
            if (acc_push) k++;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_pre_count: got %0d expected 5", count); end
        drive_cmd(100 + k); s_valid = 1'b1; m_ready = 1'b1;
        acc_push = s_ready;
        checks++; if (m_addr !== exp_addr(100)) begin errors++; $display("FAIL simul_head: got %0h expected %0h", m_addr, exp_addr(100)); end
        tick();
        if (acc_push) k++;
        rd++;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_count_hold: got %0d expected 5", count); end
        cyc = 0;
        while (rd < 40 && cyc < 400) begin
            if (k < 40) begin drive_cmd(100 + k); s_valid = 1'b1; end
            else s_valid = 1'b0;
            m_ready  = (cyc % 3 != 1);
            acc_push = s_valid && s_ready;
            acc_pop  = m_valid && m_ready;
            if (m_valid) begin
                checks++;
                if (m_id !== exp_id(100 + rd) || m_addr !== exp_addr(100 + rd) || m_len !== exp_len(100 + rd)) begin
                    errors++;
                    $display("FAIL simul_order[%0d]: got id=%0h addr=%0h expected id=%0h addr=%0h", rd, m_id, m_addr, exp_id(100 + rd), exp_addr(100 + rd));
                end
            end
            tick();
            if (acc_push) k++;
            if (acc_pop) rd++;
            cyc++;
        end
        s_valid = 1'b0; m_ready = 1'b0;
        checks++; if (rd !== 40) begin errors++; $display("FAIL simul_timeout: got %0d delivered expected 40", rd); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL simul_end_count: got %0d expected 0", count); end
    endtask

    task automatic push_raw(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        s_id = 5'd7; s_addr = addr; s_len = len; s_size = size; s_burst = burst; s_user = 9'h0aa;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

`ifdef BRDG_CMD_4K_SPLIT_EN
    task automatic test_split();
        push_raw(64'h0FC0, 8'd3, 3'd6, 2'b01);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 64'h0FC0 || m_len !== 8'd0 || m_split !== 1'b1) begin
            errors++;
            $display("FAIL split_first: got v=%0b addr=%0h len=%0d split=%0b expected v=1 addr=fc0 len=0 split=1", m_valid, m_addr, m_len, m_split);
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 64'h1000 || m_len !== 8'd2 || m_split !== 1'b0 || m_id !== 5'd7 || m_size !== 3'd6) begin
            errors++;
            $display("FAIL split_second: got v=%0b addr=%0h len=%0d split=%0b id=%0h expected v=1 addr=1000 len=2 split=0 id=7", m_valid, m_addr, m_len, m_split, m_id);
        end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL split_count_mid: got %0d expected 1", count); end
        tick();
        m_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL split_count_end: got %0d expected 0", count); end
        push_raw(64'h0FC0, 8'd3, 3'd6, 2'b00);
        checks++;
        if (m_addr !== 64'h0FC0 || m_len !== 8'd3 || m_split !== 1'b0) begin
            errors++;
            $display("FAIL split_fixed_pass: got addr=%0h len=%0d split=%0b expected addr=fc0 len=3 split=0", m_addr, m_len, m_split);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL split_fixed_pop: got %0d expected 0", count); end
    endtask
`else
    task automatic test_split();
        push_raw(64'h0FC0, 8'd3, 3'd6, 2'b01);
        checks++;
        if (m_valid !== 1'b1 || m_addr !== 64'h0FC0 || m_len !== 8'd3 || m_split !== 1'b0) begin
            errors++;
            $display("FAIL nosplit_pass: got v=%0b addr=%0h len=%0d split=%0b expected v=1 addr=fc0 len=3 split=0", m_valid, m_addr, m_len, m_split);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL nosplit_pop: got %0d expected 0", count); end
    endtask
`endif

    task automatic test_reset_mid();
        push_raw(64'h0FC0, 8'd3, 3'd6, 2'b01);
        push_raw(64'h2000, 8'd1, 3'd2, 2'b01);
        push_raw(64'h3000, 8'd1, 3'd2, 2'b01);
        checks++; if (count !== 5'd3) begin errors++; $display("FAIL rstmid_count3: got %0d expected 3", count); end
`ifdef BRDG_CMD_4K_SPLIT_EN
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (count !== 5'd3 || m_addr !== 64'h1000 || m_split !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_second: got count=%0d addr=%0h split=%0b expected count=3 addr=1000 split=0", count, m_addr, m_split);
        end
`endif
        rst = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m_valid: got %0b expected 0", m_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready_low: got %0b expected 0", s_ready); end
        rst = 1'b0;
        tick();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready_high: got %0b expected 1", s_ready); end
        checks++; if (m_valid !== 1'b0 || m_split !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got v=%0b split=%0b expected 0 0", m_valid, m_split); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul();
        test_split();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
